// File: rtl/secuenciador_pkg.sv
// Shared definitions for the microprogram sequencer: operation codes,
// condition-select constants and default sizes.
package secuenciador_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_CONT    = 2'b00,
    OP_SALTO   = 2'b01,
    OP_LLAMADA = 2'b10,
    OP_RETORNO = 2'b11
  } op_e;

  localparam logic [2:0] SEL_SIEMPRE = 3'd6;
  localparam logic [2:0] SEL_NUNCA   = 3'd7;

endpackage

// File: rtl/pila_retorno.sv
// Return-address LIFO. The top entry is read combinationally so that a pop can
// redirect the sequencer in the same cycle; contents are never reset.
module pila_retorno #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] wr_idx, rd_idx;

  assign full   = (ptr_q == PW'(DEPTH));
  assign empty  = (ptr_q == '0);
  assign wr_idx = ptr_q[IW-1:0];
  assign rd_idx = IW'(ptr_q - PW'(1));
  assign dout   = mem[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full)
      ptr_d = ptr_q + PW'(1);
    else if (pop && !empty)
      ptr_d = ptr_q - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  // Storage carries no reset: an emptied pointer makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/secuenciador_micro.sv
// Microprogram sequencer: condition select, next-address choice and call/return
// stack. Define SECUENCIADOR_CONTADOR_SALTOS_EN to add the taken-branch counter.
module secuenciador_micro
  import secuenciador_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HABILITAR,
  input  logic [1:0]        OP,
  input  logic [2:0]        SEL,
  input  logic              POLARIDAD,
  input  logic [5:0]        CONDICIONES,
  input  logic [ADDR_W-1:0] DIR_SALTO,
  output logic [ADDR_W-1:0] DIRECCION,
  output logic              PILA_LLENA,
  output logic              PILA_VACIA,
  output logic              ERROR_PILA
`ifdef SECUENCIADOR_CONTADOR_SALTOS_EN
  ,
  output logic [15:0]       SALTOS_TOMADOS
`endif
);

  op_e               op;
  logic [7:0]        cond_vec;
  logic              cond;
  logic [ADDR_W-1:0] dir_q, dir_d, inc;
  logic              err_q, err_d;
  logic              push, pop, taken;
  logic [ADDR_W-1:0] pila_dout;
  logic              pila_full, pila_empty;

  assign op = op_e'(OP);
  // Index 6 is constant true, index 7 constant false.
  assign cond_vec = {1'b0, 1'b1, CONDICIONES};
  assign cond     = cond_vec[SEL] ^ POLARIDAD;
  assign inc      = dir_q + ADDR_W'(1);

  always_comb begin
    dir_d = dir_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    taken = 1'b0;
    if (HABILITAR) begin
      dir_d = inc;
      unique case (op)
        OP_CONT: ;
        OP_SALTO: begin
          if (cond) begin
            dir_d = DIR_SALTO;
            taken = 1'b1;
          end
        end
        OP_LLAMADA: begin
          if (cond && !pila_full) begin
            push  = 1'b1;
            dir_d = DIR_SALTO;
            taken = 1'b1;
          end else if (cond) begin
            err_d = 1'b1;
          end
        end
        OP_RETORNO: begin
          if (cond && !pila_empty) begin
            pop   = 1'b1;
            dir_d = pila_dout;
            taken = 1'b1;
          end else if (cond) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dir_q <= '0;
      err_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end

  pila_retorno #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_pila (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .dout  (pila_dout),
    .full  (pila_full),
    .empty (pila_empty)
  );

  assign DIRECCION  = dir_q;
  assign PILA_LLENA = pila_full;
  assign PILA_VACIA = pila_empty;
  assign ERROR_PILA = err_q;

`ifdef SECUENCIADOR_CONTADOR_SALTOS_EN
  logic [15:0] saltos_q, saltos_d;

  always_comb begin
    saltos_d = saltos_q;
    if (taken && saltos_q != 16'hFFFF)
      saltos_d = saltos_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      saltos_q <= '0;
    else
      saltos_q <= saltos_d;
  end

  assign SALTOS_TOMADOS = saltos_q;
`else
  logic unused_taken;
  assign unused_taken = taken;
`endif

endmodule

// File: tb/tb_secuenciador_micro.sv
// Self-checking bench for secuenciador_micro: directed scenarios followed by
// randomized operations, compared against a queue-based behavioural model.
module tb_secuenciador_micro;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       HABILITAR = 1'b0;
  logic [1:0] OP = 2'b00;
  logic [2:0] SEL = 3'd0;
  logic       POLARIDAD = 1'b0;
  logic [5:0] CONDICIONES = 6'd0;
  logic [7:0] DIR_SALTO = 8'd0;
  logic [7:0] DIRECCION;
  logic       PILA_LLENA, PILA_VACIA, ERROR_PILA;
`ifdef SECUENCIADOR_CONTADOR_SALTOS_EN
  logic [15:0] SALTOS_TOMADOS;
`endif

  secuenciador_micro dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .HABILITAR   (HABILITAR),
    .OP          (OP),
    .SEL         (SEL),
    .POLARIDAD   (POLARIDAD),
    .CONDICIONES (CONDICIONES),
    .DIR_SALTO   (DIR_SALTO),
    .DIRECCION   (DIRECCION),
    .PILA_LLENA  (PILA_LLENA),
    .PILA_VACIA  (PILA_VACIA),
`ifdef SECUENCIADOR_CONTADOR_SALTOS_EN
    .ERROR_PILA  (ERROR_PILA),
    .SALTOS_TOMADOS (SALTOS_TOMADOS)
`else
    .ERROR_PILA  (ERROR_PILA)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_dir;
  int m_stk[$];
  bit m_err;
  int m_saltos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dir = 0;
    m_stk.delete();
    m_err = 1'b0;
    m_saltos = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dir"},   {24'd0, DIRECCION}, m_dir);
    check({tag, ".llena"}, {31'd0, PILA_LLENA}, (m_stk.size() == 4) ? 1 : 0);
    check({tag, ".vacia"}, {31'd0, PILA_VACIA}, (m_stk.size() == 0) ? 1 : 0);
    check({tag, ".err"},   {31'd0, ERROR_PILA}, {31'd0, m_err});
`ifdef SECUENCIADOR_CONTADOR_SALTOS_EN
    check({tag, ".saltos"}, {16'd0, SALTOS_TOMADOS}, m_saltos);
`endif
  endtask

  function automatic void model_step(input bit en, input int op, input int sel, input bit pol,
                                     input logic [5:0] conds, input int tgt);
    bit c;
    int inc;
    bit jumped;
    if (!en) return;
    c = ((sel < 6) ? conds[sel] : (sel == 6)) ^ pol;
    inc = (m_dir + 1) % 256;
    jumped = 1'b0;
    case (op)
      1: if (c) jumped = 1'b1;
      2: if (c) begin
           if (m_stk.size() < 4) begin
             m_stk.push_back(inc);
             jumped = 1'b1;
           end else m_err = 1'b1;
         end
      3: if (c) begin
           if (m_stk.size() > 0) begin
             tgt = m_stk.pop_back();
             jumped = 1'b1;
           end else m_err = 1'b1;
         end
      default: ;
    endcase
    m_dir = jumped ? tgt : inc;
    if (jumped && m_saltos < 65535) m_saltos++;
  endfunction

  task automatic cycle(input string tag, input bit en, input int op, input int sel, input bit pol,
                       input logic [5:0] conds, input int tgt);
    HABILITAR   = en;
    OP          = 2'(op);
    SEL         = 3'(sel);
    POLARIDAD   = pol;
    CONDICIONES = conds;
    DIR_SALTO   = 8'(tgt);
    @(posedge CLK);
    model_step(en, op, sel, pol, conds, tgt);
    #1;
    $display("%s en=%0d op=%0d sel=%0d pol=%0d cond=%b tgt=%02h -> dir=%02h llena=%0d vacia=%0d err=%0d",
             tag, en, op, sel, pol, conds, tgt, DIRECCION, PILA_LLENA, PILA_VACIA, ERROR_PILA);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    for (int i = 0; i < 5; i++) cycle("cont", 1, 0, 0, 0, 6'd0, 0);
    check("cont5", {24'd0, DIRECCION}, 32'h05);

    cycle("salto_pol0", 1, 1, 2, 0, 6'b000100, 8'h40);
    check("salto40", {24'd0, DIRECCION}, 32'h40);
    cycle("salto_pol1", 1, 1, 2, 1, 6'b000100, 8'h40);
    check("salto_inc", {24'd0, DIRECCION}, 32'h41);

    cycle("to10", 1, 1, 6, 0, 6'd0, 8'h10);
    cycle("call80", 1, 2, 6, 0, 6'd0, 8'h80);
    check("call80.dir", {24'd0, DIRECCION}, 32'h80);
    cycle("ret11", 1, 3, 6, 0, 6'd0, 8'h00);
    check("ret11.dir", {24'd0, DIRECCION}, 32'h11);

    for (int i = 0; i < 4; i++) cycle("nest", 1, 2, 6, 0, 6'd0, 8'h20 + 8'h10 * i);
    check("nest.llena", {31'd0, PILA_LLENA}, 32'd1);
    cycle("overflow", 1, 2, 6, 0, 6'd0, 8'hA0);
    check("overflow.dir", {24'd0, DIRECCION}, 32'h51);
    check("overflow.err", {31'd0, ERROR_PILA}, 32'd1);
    for (int i = 0; i < 4; i++) cycle("unwind", 1, 3, 6, 0, 6'd0, 8'h00);
    check("unwind.dir", {24'd0, DIRECCION}, 32'h12);
    check("unwind.err", {31'd0, ERROR_PILA}, 32'd1);

    cycle("toFF", 1, 1, 6, 0, 6'd0, 8'hFF);
    cycle("wrap", 1, 0, 0, 0, 6'd0, 0);
    check("wrap.dir", {24'd0, DIRECCION}, 32'h00);

    do_reset("reset2");
    cycle("underflow", 1, 3, 6, 0, 6'd0, 8'h33);
    check("underflow.dir", {24'd0, DIRECCION}, 32'h01);
    check("underflow.err", {31'd0, ERROR_PILA}, 32'd1);
    cycle("hold", 0, 1, 6, 0, 6'd0, 8'h77);
    check("hold.dir", {24'd0, DIRECCION}, 32'h01);

    cycle("pre_rst", 1, 2, 6, 0, 6'd0, 8'h90);
    do_reset("mid_rst");
    check("mid_rst.dir", {24'd0, DIRECCION}, 32'h00);

`ifdef SECUENCIADOR_CONTADOR_SALTOS_EN
    for (int i = 0; i < 3; i++) cycle("cnt_taken", 1, 1, 6, 0, 6'd0, 8'h08 * (i + 1));
    cycle("cnt_not", 1, 1, 7, 0, 6'd0, 8'h44);
    check("cnt3", {16'd0, SALTOS_TOMADOS}, 32'd3);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cycle("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 3),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 6,
              $urandom_range(0, 3) == 0, 6'($urandom), $urandom_range(0, 255));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/secuenciador_micro.md
Name: secuenciador_micro

Overview:
- Microprogram sequencer that produces the control-store address each cycle.
- A 6-way condition select chooses whether the address counter loads a branch target or simply increments.
- Holds a small return-address stack for microsubroutine call and return.
- Sits between the control ROM (driven by DIRECCION) and the datapath status flags (CONDICIONES).

Parameters:
- ADDR_W, 8, width of the microprogram address.
- STACK_DEPTH, 4, number of return-address entries (power of two, minimum 2).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- HABILITAR  input  1  sequencer advances only when 1; otherwise all state holds.
- OP  input  2  operation: 00 CONT, 01 SALTO, 10 LLAMADA, 11 RETORNO.
- SEL  input  3  condition select: 0-5 pick CONDICIONES[SEL]; 6 is constant true; 7 is constant false.
- POLARIDAD  input  1  when 1, the selected condition is inverted.
- CONDICIONES  input  6  datapath status flags; bit n is selected by SEL=n.
- DIR_SALTO  input  ADDR_W  branch or call target.
- DIRECCION  output  ADDR_W  registered current microaddress.
- PILA_LLENA  output  1  stack holds STACK_DEPTH entries.
- PILA_VACIA  output  1  stack holds 0 entries.
- ERROR_PILA  output  1  sticky overflow/underflow flag.

Behaviour:
- Clock and reset: single clock CLK; RESET is asynchronous, active-high.
- Reset values:
  - DIRECCION=0.
  - Stack pointer=0, so PILA_VACIA=1 and PILA_LLENA=0.
  - ERROR_PILA=0.
  - Stack contents are don't-care.
- Condition evaluation (combinational): cond = (SEL<6 ? CONDICIONES[SEL] : SEL==6) XOR POLARIDAD.
- Update timing: all state updates on the rising CLK edge when HABILITAR=1. One-cycle latency: inputs sampled at edge k appear on DIRECCION after edge k.
- Next-address rules (inc = DIRECCION+1, modulo 2^ADDR_W; all-ones wraps to 0):
  - CONT: next = inc; cond is ignored.
  - SALTO: next = cond ? DIR_SALTO : inc.
  - LLAMADA, cond=1, stack not full: push inc; next = DIR_SALTO.
  - LLAMADA, cond=1, stack full: no push; next = inc; ERROR_PILA<=1.
  - LLAMADA, cond=0: next = inc; no stack change.
  - RETORNO, cond=1, stack not empty: pop; next = popped value.
  - RETORNO, cond=1, stack empty: next = inc; ERROR_PILA<=1.
  - RETORNO, cond=0: next = inc; no stack change.
- Stack:
  - LIFO; pointer range 0..STACK_DEPTH.
  - PILA_LLENA and PILA_VACIA are decoded from the registered pointer.
  - Only one push or pop per cycle (guaranteed by OP encoding).
- ERROR_PILA is cleared only by RESET.
- HABILITAR=0: DIRECCION, stack and ERROR_PILA all hold, regardless of OP.
- RESET asserted mid-call or mid-return: state returns to reset values immediately (asynchronous); the stack is effectively emptied.

Optional Feature:
- Macro: SECUENCIADOR_CONTADOR_SALTOS_EN.
- Defined:
  - Adds output SALTOS_TOMADOS, 16 bits.
  - Increments by 1 on each enabled cycle in which the next address is not inc (taken SALTO, successful LLAMADA, successful RETORNO).
  - Saturates at 16'hFFFF; resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package secuenciador_pkg:
  - OP codes: OP_CONT, OP_SALTO, OP_LLAMADA, OP_RETORNO.
  - SEL constants: SEL_SIEMPRE=6, SEL_NUNCA=7.
  - Default ADDR_W and STACK_DEPTH.
- Sub-module pila_retorno: parameterised LIFO with push, pop, din, dout, full and empty. It is the natural unit for separate verification.
- Condition select and next-address logic stay in the top module.

Test Plan:
- Reset then OP=CONT for 5 cycles -> DIRECCION 0,1,2,3,4,5; PILA_VACIA=1. ADDR_W=8 starting at 8'hFF with CONT -> wraps to 8'h00.
- SALTO, DIR_SALTO=8'h40, SEL=2, CONDICIONES=6'b000100, POLARIDAD=0 -> DIRECCION=8'h40. Same with POLARIDAD=1 -> DIRECCION=inc.
- At address 8'h10, LLAMADA SEL=6 target 8'h80 -> DIRECCION=8'h80, PILA_VACIA=0. Then RETORNO SEL=6 -> DIRECCION=8'h11, PILA_VACIA=1.
- 4 nested LLAMADA -> PILA_LLENA=1. A 5th LLAMADA -> DIRECCION=inc, ERROR_PILA=1 and stays 1 after 4 RETORNOs unwind correctly.
- RETORNO with stack empty -> DIRECCION=inc, ERROR_PILA=1. HABILITAR=0 with OP=SALTO SEL=6 -> DIRECCION unchanged. RESET pulse between clock edges -> DIRECCION=0 before the next edge.
- With SECUENCIADOR_CONTADOR_SALTOS_EN: 3 taken SALTOs plus 1 non-taken SALTO -> SALTOS_TOMADOS=3.
